// File: rtl/calc_param.sv
// Parametrised keypad calculator: decimal operand entry, add/sub/mul/div with
// iterative multiply/divide, binary->BCD conversion and a scanned BCD display.
// Ports:
//   clock, reset      rising-edge clock, asynchronous active-high reset
//   cmd, cmd_valid    keypad code (0-9 digit, A-D op, E equals, F backspace) + qualifier
//   status            00 ERROR, 01 BUSY, 10 READY
//   data, pos         BCD digit for display position pos (0 = least significant)
//   neg               displayed value is negative
module calc_param #(
   parameter int unsigned NDIG = 8,
   localparam int unsigned W = $clog2(10**NDIG),
   localparam int unsigned PW = (NDIG > 1) ? $clog2(NDIG) : 1
) (
   input  logic          clock,
   input  logic          reset,
   input  logic [3:0]    cmd,
   input  logic          cmd_valid,
   output logic [1:0]    status,
   output logic [3:0]    data,
   output logic [PW-1:0] pos,
   output logic          neg
);

   localparam int unsigned DW = 4 * NDIG;
   localparam int unsigned CW = $clog2(W + 1);
   localparam logic [2*W-1:0] MAXV = (2*W)'(10**NDIG - 1);
   localparam logic [W-1:0]   FULL = W'(10**(NDIG - 1));

   typedef enum logic [2:0] {
      ST_ENTER_A, ST_ENTER_B, ST_COMPUTE, ST_CONVERT, ST_SHOW, ST_ERROR
   } state_t;

   typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_t;

   state_t          state_q, state_d;
   op_t             op_q, op_d;
   logic [W-1:0]    acc_q, acc_d;
   logic [W-1:0]    a_q, a_d;
   logic [W-1:0]    b_q, b_d;
   logic [2*W-1:0]  res_q, res_d;
   logic [2*W-1:0]  mc_q, mc_d;
   logic [W-1:0]    rem_q, rem_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [DW-1:0]   disp_q, disp_d;
   logic [1:0]      status_q, status_d;
   logic [3:0]      data_q, data_d;
   logic [PW-1:0]   pos_q, pos_d;
   logic            neg_q, neg_d;

   logic            accept, is_digit, is_op, done;
   logic [2*W-1:0]  result;
   logic [W:0]      rem_sh;
   logic [W-1:0]    quo;
   logic [DW-1:0]   adj;

   // Next-state, datapath and display scan
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      acc_d    = acc_q;
      a_d      = a_q;
      b_d      = b_q;
      res_d    = res_q;
      mc_d     = mc_q;
      rem_d    = rem_q;
      cnt_d    = cnt_q;
      disp_d   = disp_q;
      neg_d    = neg_q;
      done     = 1'b0;
      result   = '0;
      rem_sh   = '0;
      quo      = '0;
      adj      = disp_q;

      accept   = cmd_valid && (status_q == 2'b10);
      is_digit = (cmd <= 4'd9);
      is_op    = (cmd >= 4'hA) && (cmd <= 4'hD);

      case (state_q)
         ST_ENTER_A, ST_ENTER_B: begin
            if (accept) begin
               if (is_digit) begin
                  // acc < 10^(NDIG-1) means room for one more digit
                  if (acc_q < FULL) begin
                     acc_d  = (acc_q << 3) + (acc_q << 1) + W'(cmd);
                     disp_d = (disp_q << 4) | DW'(cmd);
                  end
               end else if (cmd == 4'hF) begin
                  acc_d  = acc_q / W'(10);
                  disp_d = disp_q >> 4;
               end else if (is_op) begin
                  op_d = op_t'(2'(cmd - 4'd10));
                  if (state_q == ST_ENTER_A) begin
                     a_d     = acc_q;
                     acc_d   = '0;
                     disp_d  = '0;
                     state_d = ST_ENTER_B;
                  end
               end else if (cmd == 4'hE && state_q == ST_ENTER_B) begin
                  // Preload the iterative engines for the latched op
                  b_d     = acc_q;
                  cnt_d   = '0;
                  mc_d    = (2*W)'(a_q);
                  rem_d   = '0;
                  res_d   = (op_q == OP_DIV) ? (2*W)'(a_q) : '0;
                  state_d = ST_COMPUTE;
               end
            end
         end

         ST_COMPUTE: begin
            neg_d = 1'b0;
            case (op_q)
               OP_ADD: begin
                  result = (2*W)'(a_q) + (2*W)'(b_q);
                  done   = 1'b1;
               end
               OP_SUB: begin
                  if (a_q < b_q) begin
                     result = (2*W)'(b_q - a_q);
                     neg_d  = 1'b1;
                  end else begin
                     result = (2*W)'(a_q - b_q);
                  end
                  done = 1'b1;
               end
               OP_MUL: begin
                  // Shift-add: multiplicand moves left, multiplier right
                  result = b_q[0] ? (res_q + mc_q) : res_q;
                  res_d  = result;
                  mc_d   = mc_q << 1;
                  b_d    = b_q >> 1;
                  cnt_d  = cnt_q + CW'(1);
                  done   = (cnt_q == CW'(W - 1));
               end
               default: begin
                  if (b_q == '0) begin
                     state_d = ST_ERROR;
                  end else begin
                     // Restoring division, quotient shifts in from the dividend register
                     rem_sh = {rem_q, res_q[W-1]};
                     quo    = res_q[W-1:0] << 1;
                     if (rem_sh >= {1'b0, b_q}) begin
                        rem_sh = rem_sh - {1'b0, b_q};
                        quo[0] = 1'b1;
                     end
                     rem_d  = W'(rem_sh);
                     result = (2*W)'(quo);
                     res_d  = result;
                     cnt_d  = cnt_q + CW'(1);
                     done   = (cnt_q == CW'(W - 1));
                  end
               end
            endcase
            if (done) begin
               if (result > MAXV) begin
                  state_d = ST_ERROR;
               end else begin
                  res_d   = result;
                  a_d     = W'(result);
                  disp_d  = '0;
                  cnt_d   = '0;
                  state_d = ST_CONVERT;
               end
            end
         end

         ST_CONVERT: begin
            if (cnt_q < CW'(W)) begin
               // Double-dabble: add 3 to digits >= 5, then shift in next binary MSB
               for (int i = 0; i < int'(NDIG); i++) begin
                  if (disp_q[4*i +: 4] >= 4'd5) begin
                     adj[4*i +: 4] = disp_q[4*i +: 4] + 4'd3;
                  end
               end
               disp_d = {adj[DW-2:0], res_q[W-1]};
               res_d  = res_q << 1;
               cnt_d  = cnt_q + CW'(1);
            end else begin
               state_d = ST_SHOW;
            end
         end

         ST_SHOW: begin
            if (accept) begin
               if (is_op) begin
                  // Chain: A already holds the result magnitude
                  op_d    = op_t'(2'(cmd - 4'd10));
                  acc_d   = '0;
                  disp_d  = '0;
                  neg_d   = 1'b0;
                  state_d = ST_ENTER_B;
               end else if (is_digit) begin
                  acc_d   = W'(cmd);
                  disp_d  = DW'(cmd);
                  neg_d   = 1'b0;
                  state_d = ST_ENTER_A;
               end
            end
         end

         default: begin
         end
      endcase

      case (state_d)
         ST_ERROR:               status_d = 2'b00;
         ST_COMPUTE, ST_CONVERT: status_d = 2'b01;
         default:                status_d = 2'b10;
      endcase

      pos_d = (pos_q == PW'(NDIG - 1)) ? '0 : pos_q + PW'(1);

      // data tracks the next pos so both update on the same edge
      if (state_d == ST_ERROR) begin
         data_d = 4'hE;
      end else if (state_d == ST_COMPUTE || state_d == ST_CONVERT) begin
         data_d = 4'h0;
      end else begin
         data_d = disp_d[{pos_d, 2'b00} +: 4];
      end
   end

   // State and output registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= ST_ENTER_A;
         op_q     <= OP_ADD;
         acc_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         res_q    <= '0;
         mc_q     <= '0;
         rem_q    <= '0;
         cnt_q    <= '0;
         disp_q   <= '0;
         status_q <= 2'b10;
         data_q   <= '0;
         pos_q    <= '0;
         neg_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         acc_q    <= acc_d;
         a_q      <= a_d;
         b_q      <= b_d;
         res_q    <= res_d;
         mc_q     <= mc_d;
         rem_q    <= rem_d;
         cnt_q    <= cnt_d;
         disp_q   <= disp_d;
         status_q <= status_d;
         data_q   <= data_d;
         pos_q    <= pos_d;
         neg_q    <= neg_d;
      end
   end

   assign status = status_q;
   assign data   = data_q;
   assign pos    = pos_q;
   assign neg    = neg_q;

endmodule

// File: tb/tb_calc_param.sv
// Self-checking bench for calc_param: vector table of operations with a
// scoreboard of expected results, plus hand sequences for reset, scan,
// entry limits, busy-time input, chaining and error lock-up.
module tb_calc_param;

   localparam int unsigned NDIG = 8;
   localparam int unsigned W    = $clog2(10**NDIG);
   localparam int unsigned PW   = $clog2(NDIG);

   logic          clock = 1'b0;
   logic          reset;
   logic [3:0]    cmd;
   logic          cmd_valid;
   logic [1:0]    status;
   logic [3:0]    data;
   logic [PW-1:0] pos;
   logic          neg;

   int checks = 0;
   int errors = 0;

   typedef struct {
      longint     a;
      logic [3:0] op;
      longint     b;
      longint     exp_val;
      logic       exp_neg;
      logic       exp_err;
      int         exp_busy;
   } vec_t;

   vec_t vecs[12];
   vec_t expq[$];

   always #5 clock = ~clock;

   calc_param #(.NDIG(NDIG)) dut (
      .clock     (clock),
      .reset     (reset),
      .cmd       (cmd),
      .cmd_valid (cmd_valid),
      .status    (status),
      .data      (data),
      .pos       (pos),
      .neg       (neg)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // All tasks start and end on a falling edge
   task automatic do_reset();
      reset = 1'b1;
      cmd = 4'h0;
      cmd_valid = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic press(input logic [3:0] c);
      cmd = c;
      cmd_valid = 1'b1;
      @(negedge clock);
      cmd_valid = 1'b0;
   endtask

   task automatic enter_num(input longint n);
      int dg[$];
      longint v;
      v = n;
      if (v == 0) dg.push_back(0);
      while (v > 0) begin
         dg.push_front(int'(v % 10));
         v = v / 10;
      end
      foreach (dg[i]) press(4'(dg[i]));
   endtask

   // Collect one full scan and rebuild the decimal value
   task automatic read_disp(output longint val);
      int     dig[NDIG];
      longint p;
      for (int i = 0; i < int'(NDIG); i++) begin
         dig[pos] = int'(data);
         @(negedge clock);
      end
      val = 0;
      p = 1;
      for (int i = 0; i < int'(NDIG); i++) begin
         val = val + longint'(dig[i]) * p;
         p = p * 10;
      end
   endtask

   task automatic wait_busy(output int n);
      n = 0;
      while (status == 2'b01 && n < 500) begin
         n++;
         @(negedge clock);
      end
      if (n >= 500) check("busy_timeout", 64'(n), 64'(0));
   endtask

   task automatic check_error_display(input string name);
      int bad;
      bad = 0;
      for (int i = 0; i < int'(NDIG); i++) begin
         if (data !== 4'hE) bad++;
         @(negedge clock);
      end
      check(name, 64'(bad), 64'(0));
   endtask

   task automatic run_vec(input vec_t v);
      vec_t   e;
      int     n;
      longint val;
      do_reset();
      enter_num(v.a);
      press(v.op);
      enter_num(v.b);
      press(4'hE);
      expq.push_back(v);
      check("busy_status", 64'(status), 64'(2'b01));
      check("busy_data", 64'(data), 64'(0));
      wait_busy(n);
      e = expq.pop_front();
      check("latency", 64'(n), 64'(e.exp_busy));
      if (e.exp_err) begin
         check("err_status", 64'(status), 64'(2'b00));
         check_error_display("err_data");
      end else begin
         check("ready_status", 64'(status), 64'(2'b10));
         check("neg", 64'(neg), 64'(e.exp_neg));
         read_disp(val);
         check("result", 64'(val), 64'(e.exp_val));
      end
   endtask

   initial begin
      longint val;
      int     n;
      logic [PW-1:0] prev;

      vecs[0]  = '{12, 4'hA, 34, 46, 1'b0, 1'b0, W + 2};
      vecs[1]  = '{5, 4'hB, 9, 4, 1'b1, 1'b0, W + 2};
      vecs[2]  = '{1234, 4'hC, 5678, 7006652, 1'b0, 1'b0, 2*W + 1};
      vecs[3]  = '{100, 4'hD, 7, 14, 1'b0, 1'b0, 2*W + 1};
      vecs[4]  = '{50, 4'hB, 20, 30, 1'b0, 1'b0, W + 2};
      vecs[5]  = '{0, 4'hC, 5, 0, 1'b0, 1'b0, 2*W + 1};
      vecs[6]  = '{99999999, 4'hD, 1, 99999999, 1'b0, 1'b0, 2*W + 1};
      vecs[7]  = '{12345678, 4'hA, 87654321, 99999999, 1'b0, 1'b0, W + 2};
      vecs[8]  = '{3, 4'hB, 3, 0, 1'b0, 1'b0, W + 2};
      vecs[9]  = '{99999999, 4'hA, 1, 0, 1'b0, 1'b1, 1};
      vecs[10] = '{7, 4'hD, 0, 0, 1'b0, 1'b1, 1};
      vecs[11] = '{99999999, 4'hC, 9, 0, 1'b0, 1'b1, W};

      // Reset values
      reset = 1'b1;
      cmd = 4'h0;
      cmd_valid = 1'b0;
      repeat (2) @(negedge clock);
      check("rst_status", 64'(status), 64'(2'b10));
      check("rst_data", 64'(data), 64'(0));
      check("rst_pos", 64'(pos), 64'(0));
      check("rst_neg", 64'(neg), 64'(0));
      reset = 1'b0;

      // Scan position wraps continuously
      prev = pos;
      n = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clock);
         if (pos !== PW'((int'(prev) + 1) % int'(NDIG))) n++;
         prev = pos;
      end
      check("pos_wrap", 64'(n), 64'(0));

      // Table-driven operations
      foreach (vecs[i]) run_vec(vecs[i]);

      // cmd_valid low is ignored; E in first operand is ignored
      do_reset();
      cmd = 4'h5;
      repeat (3) @(negedge clock);
      read_disp(val);
      check("valid_low", 64'(val), 64'(0));
      press(4'h3);
      press(4'hE);
      check("e_in_a_status", 64'(status), 64'(2'b10));
      read_disp(val);
      check("e_in_a_disp", 64'(val), 64'(3));

      // Backspace: no-op at zero, removes last digit
      do_reset();
      press(4'hF);
      read_disp(val);
      check("bksp_zero", 64'(val), 64'(0));
      press(4'h1);
      press(4'h2);
      press(4'hF);
      read_disp(val);
      check("bksp", 64'(val), 64'(1));

      // Digit limit, backspace, then overflow lock-up
      do_reset();
      repeat (NDIG + 1) press(4'h9);
      read_disp(val);
      check("digit_limit", 64'(val), 64'(99999999));
      press(4'hF);
      read_disp(val);
      check("bksp_full", 64'(val), 64'(9999999));
      press(4'h9);
      press(4'hC);
      press(4'h9);
      press(4'hE);
      wait_busy(n);
      check("ovf_latency", 64'(n), 64'(W));
      check("ovf_status", 64'(status), 64'(2'b00));
      press(4'h5);
      press(4'hF);
      check("err_ignore", 64'(status), 64'(2'b00));
      check_error_display("ovf_data");
      reset = 1'b1;
      #1;
      check("err_rst_status", 64'(status), 64'(2'b10));
      check("err_rst_pos", 64'(pos), 64'(0));
      @(negedge clock);
      reset = 1'b0;

      // Input held during BUSY has no effect
      do_reset();
      press(4'h2);
      press(4'hA);
      press(4'h3);
      press(4'hE);
      cmd = 4'h9;
      cmd_valid = 1'b1;
      repeat (5) @(negedge clock);
      cmd_valid = 1'b0;
      wait_busy(n);
      check("busy_ign_latency", 64'(n + 5), 64'(W + 2));
      read_disp(val);
      check("busy_ign_result", 64'(val), 64'(5));

      // Negative result, then chain into an add
      do_reset();
      press(4'h5);
      press(4'hB);
      press(4'h9);
      press(4'hE);
      wait_busy(n);
      read_disp(val);
      check("chain_sub", 64'(val), 64'(4));
      check("chain_sub_neg", 64'(neg), 64'(1));
      press(4'hA);
      check("chain_neg_clr", 64'(neg), 64'(0));
      press(4'h4);
      press(4'hE);
      wait_busy(n);
      read_disp(val);
      check("chain_add", 64'(val), 64'(8));
      check("chain_add_neg", 64'(neg), 64'(0));

      // Digit after a result starts fresh entry
      press(4'h7);
      read_disp(val);
      check("fresh_entry", 64'(val), 64'(7));
      press(4'hC);
      press(4'h6);
      press(4'hE);
      wait_busy(n);
      read_disp(val);
      check("fresh_mul", 64'(val), 64'(42));

      // Reset in the middle of a multiply aborts at once
      do_reset();
      press(4'h3);
      press(4'hC);
      press(4'h4);
      press(4'hE);
      repeat (10) @(negedge clock);
      reset = 1'b1;
      #1;
      check("abort_status", 64'(status), 64'(2'b10));
      check("abort_pos", 64'(pos), 64'(0));
      @(negedge clock);
      reset = 1'b0;
      read_disp(val);
      check("abort_disp", 64'(val), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
